// File: rtl/mult_job_dispatcher_if.sv
// Bundled handshake signals between the job dispatcher, its upstream producer,
// the attached 4x4 shift-add multiplier and the downstream consumer.
interface mult_job_dispatcher_if;
  logic        In_valid;
  logic        In_ready;
  logic [3:0]  In_a;
  logic [3:0]  In_b;
  logic        St;
  logic [3:0]  Mplier;
  logic [3:0]  Mcand;
  logic        Done;
  logic [7:0]  Result;
  logic        Out_valid;
  logic        Out_ready;
  logic [7:0]  Out_prod;
  logic        Out_err;
  logic        Sum_clr;
  logic [11:0] Sum;

  // slave: the dispatcher itself
  modport slave (
    input  In_valid, In_a, In_b, Done, Result, Out_ready, Sum_clr,
    output In_ready, St, Mplier, Mcand, Out_valid, Out_prod, Out_err, Sum
  );

  // master: everything surrounding the dispatcher
  modport master (
    output In_valid, In_a, In_b, Done, Result, Out_ready, Sum_clr,
    input  In_ready, St, Mplier, Mcand, Out_valid, Out_prod, Out_err, Sum
  );
endinterface

// File: rtl/mult_job_dispatcher.sv
// Feeds one operand pair at a time to a shift-add multiplier, captures the
// product (or a timeout error) for downstream, and keeps a running sum.
//
// state | meaning
// IDLE  | ready for an operand pair
// ISSUE | St pulse to the multiplier, WAIT timer cleared
// WAIT  | waiting for Done, abort after TIMEOUT cycles
// HOLD  | product/error offered downstream until Out_ready
module mult_job_dispatcher #(
  parameter int TIMEOUT = 16
) (
  input logic            Clk,
  input logic            Rst_n,
  mult_job_dispatcher_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TC = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state;
  logic          rst_meta;
  logic          rst_sync_n;
  logic [TW-1:0] timer;
  logic          in_ready;
  logic          st;
  logic [3:0]    mplier;
  logic [3:0]    mcand;
  logic          out_valid;
  logic [7:0]    out_prod;
  logic          out_err;
  logic [11:0]   sum;

  // Assertion is immediate; release reaches the core two edges later.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= IDLE;
      timer     <= '0;
      in_ready  <= 1'b1;
      st        <= 1'b0;
      mplier    <= '0;
      mcand     <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_err   <= 1'b0;
      sum       <= '0;
    end else begin
      st <= 1'b0;
      if (bus.Sum_clr) begin
        sum <= '0;
      end
      case (state)
        IDLE: begin
          if (bus.In_valid) begin
            mplier   <= bus.In_a;
            mcand    <= bus.In_b;
            in_ready <= 1'b0;
            st       <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Done wins over a coincident timeout; a coincident clear keeps this product.
          if (bus.Done) begin
            out_prod  <= bus.Result;
            out_err   <= 1'b0;
            sum       <= (bus.Sum_clr ? 12'd0 : sum) + {4'd0, bus.Result};
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (timer == TC) begin
            out_prod  <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HOLD: begin
          if (bus.Out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.St        = st;
  assign bus.Mplier    = mplier;
  assign bus.Mcand     = mcand;
  assign bus.Out_valid = out_valid;
  assign bus.Out_prod  = out_prod;
  assign bus.Out_err   = out_err;
  assign bus.Sum       = sum;

endmodule

// File: doc/mult_job_dispatcher.md
MULT_JOB_DISPATCHER -- requirements
Module: mult_job_dispatcher

Interface
REQ-001 Parameter: TIMEOUT, default 16, WAIT cycles allowed for Done before abort; SHALL be >= 10.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 In_valid  input  1  upstream operand pair valid.
REQ-005 In_ready  output  1  dispatcher can accept an operand pair.
REQ-006 In_a  input  4  multiplier operand.
REQ-007 In_b  input  4  multiplicand operand.
REQ-008 St  output  1  start pulse to the 4x4 shift-add multiplier.
REQ-009 Mplier  output  4  multiplier operand to the multiplier.
REQ-010 Mcand  output  4  multiplicand operand to the multiplier.
REQ-011 Done  input  1  multiplier completion flag, high for one cycle.
REQ-012 Result  input  8  multiplier product, meaningful only while Done=1.
REQ-013 Out_valid  output  1  product available downstream.
REQ-014 Out_ready  input  1  downstream accepts product.
REQ-015 Out_prod  output  8  captured product.
REQ-016 Out_err  output  1  product aborted by timeout.
REQ-017 Sum_clr  input  1  synchronous clear of running sum.
REQ-018 Sum  output  12  running sum of successful products.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD; one job in flight at a time.
REQ-020 IDLE: In_ready=1; on In_valid=1, latch In_a->Mplier, In_b->Mcand, go ISSUE; else stay.
REQ-021 In_ready SHALL be 0 in ISSUE, WAIT, HOLD.
REQ-022 ISSUE: St=1 for exactly this one cycle, clear WAIT timer, go WAIT.
REQ-023 St SHALL be 0 in every state other than ISSUE.
REQ-024 Mplier/Mcand SHALL hold their latched values from ISSUE through end of HOLD.
REQ-025 WAIT: if Done=1, Out_prod<=Result, Out_err<=0, Sum<=Sum+Result, go HOLD.
REQ-026 WAIT: if Done=0, timer increments; on the TIMEOUT-th WAIT cycle without Done, Out_prod<=0, Out_err<=1, Sum unchanged, go HOLD.
REQ-027 Done=1 on the same cycle the timer expires SHALL count as success (Done has priority).
REQ-028 Done seen in IDLE, ISSUE or HOLD SHALL be ignored.
REQ-029 HOLD: Out_valid=1, Out_prod/Out_err stable; on Out_ready=1 go IDLE; Out_valid=0 in all other states.
REQ-030 No bypass: earliest new acceptance is the cycle after the HOLD handshake.
REQ-031 Sum SHALL add Result zero-extended to 12 bits, wrap modulo 4096.
REQ-032 Sum_clr=1 SHALL set Sum to 0; if coincident with a REQ-025 add, Sum<=Result.
REQ-033 Latency: Done on WAIT cycle N -> Out_valid from next cycle; N=5 (Mplier=0) to 9 (Mplier=0xF).

Reset
REQ-034 Rst_n=0 SHALL immediately force IDLE, St=0, In_ready=1, Out_valid=0, Out_err=0, Out_prod=0, Mplier=0, Mcand=0, Sum=0, timer=0.
REQ-035 Reset mid-job SHALL drop the job without output; a later stray Done SHALL be ignored per REQ-028.
REQ-036 Rst_n deassertion SHALL be synchronised to Clk internally; first acceptance no earlier than second Clk edge after release.

Verification
REQ-037 In_a=3, In_b=5 with multiplier attached -> one St pulse, Done on WAIT cycle 7, Out_prod=0x0F, Out_err=0, Sum=0x00F.
REQ-038 In_a=0xF, In_b=0xF -> Done on WAIT cycle 9, Out_prod=0xE1, Sum increments by 0x0E1.
REQ-039 Done tied low -> after 16 WAIT cycles Out_valid=1, Out_prod=0, Out_err=1, Sum unchanged.
REQ-040 Out_ready held low 20 cycles in HOLD -> Out_valid/Out_prod stable, In_ready=0, no St pulse.
REQ-041 Sum=0xFA0 then product 0xE1 -> Sum=0x081; Sum_clr with Done in WAIT on product 0x0F -> Sum=0x00F.
REQ-042 Rst_n low during WAIT, then Done pulse after release -> no Out_valid, In_ready=1, Sum=0.
